// File: rtl/vector_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vector_pc_sequencer
// Purpose  : Program-counter sequencer with start/stall/branch/halt control
//            and a saturating RUN-cycle counter. Branch loading is compiled in
//            only when VPS_BRANCH_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module vector_pc_sequencer #(
    parameter int              PC_W     = 20,
    parameter logic [PC_W-1:0] START_PC = '0,
    parameter logic [PC_W-1:0] END_PC   = '1,
    parameter logic [PC_W-1:0] STEP     = {{(PC_W-1){1'b0}}, 1'b1}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stall,
    input  logic            br_valid,
    input  logic [PC_W-1:0] br_target,
    output logic [PC_W-1:0] pc,
    output logic            pc_valid,
    output logic            halted,
    output logic [31:0]     run_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     run_cnt_q, run_cnt_d;
    logic            w_br_take;

`ifdef VPS_BRANCH_EN
    assign w_br_take = br_valid;
`else
    // Branch ports stay on the boundary but have no effect in this build.
    logic w_unused_br;
    assign w_br_take   = 1'b0;
    assign w_unused_br = br_valid;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        run_cnt_d = run_cnt_q;

        if ((state_q == S_RUN) && (run_cnt_q != 32'hFFFF_FFFF)) begin
            run_cnt_d = run_cnt_q + 32'd1;
        end

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = START_PC;
                end
            end
            S_RUN: begin
                // Reaching END_PC outranks both stall and branch.
                if (pc_q == END_PC) begin
                    state_d = S_HALT;
                end else if (stall) begin
                    state_d = S_STALL;
                end else if (w_br_take) begin
                    pc_d = br_target;
                end else begin
                    pc_d = pc_q + STEP;
                end
            end
            S_STALL: begin
                if (!stall) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= START_PC;
            run_cnt_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = (state_q == S_RUN);
    assign halted   = (state_q == S_HALT);
    assign run_cnt  = run_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_pc_sequencer
// Purpose  : Self-checking bench: directed scenarios plus random stimulus
//            compared against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_pc_sequencer;

`ifdef VPS_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif
    localparam int MI = 0, MR = 1, MS = 2, MH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rst = 1'b0, start = 1'b0, stall = 1'b0, br_valid = 1'b0;
    logic [19:0] br_target = '0;
    logic [19:0] pc;
    logic        pc_valid, halted;
    logic [31:0] run_cnt;

    // Halt instance: START 1, END 10, STEP 3
    logic        rst1 = 1'b1, start1 = 1'b0, stall1 = 1'b0;
    logic [19:0] pc1;
    logic        pc_valid1, halted1;
    logic [31:0] run_cnt1;

    // Wrap instance: 4-bit PC, START 14, END 0, STEP 5
    logic        rst2 = 1'b1, start2 = 1'b0;
    logic [3:0]  pc2;
    logic        pc_valid2, halted2;
    logic [31:0] run_cnt2;

    vector_pc_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .br_valid(br_valid), .br_target(br_target),
        .pc(pc), .pc_valid(pc_valid), .halted(halted), .run_cnt(run_cnt)
    );

    vector_pc_sequencer #(
        .PC_W(20), .START_PC(20'd1), .END_PC(20'd10), .STEP(20'd3)
    ) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .stall(stall1),
        .br_valid(1'b0), .br_target(20'd0),
        .pc(pc1), .pc_valid(pc_valid1), .halted(halted1), .run_cnt(run_cnt1)
    );

    vector_pc_sequencer #(
        .PC_W(4), .START_PC(4'd14), .END_PC(4'd0), .STEP(4'd5)
    ) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .stall(1'b0),
        .br_valid(1'b0), .br_target(4'd0),
        .pc(pc2), .pc_valid(pc_valid2), .halted(halted2), .run_cnt(run_cnt2)
    );

    int errors = 0;
    int checks = 0;

    // Reference model of the default instance
    int          m_mode = MI;
    logic [19:0] m_pc   = '0;
    longint      m_cnt  = 0;

    task automatic model_edge();
        if (rst) begin
            m_mode = MI;
            m_pc   = 20'd0;
            m_cnt  = 0;
        end else begin
            if (m_mode == MR && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
            case (m_mode)
                MI, MH: if (start) begin m_mode = MR; m_pc = 20'd0; end
                MR: begin
                    if (m_pc == 20'hFFFFF)         m_mode = MH;
                    else if (stall)                m_mode = MS;
                    else if (BR_EN && br_valid)    m_pc = br_target;
                    else                           m_pc = m_pc + 20'd1;
                end
                MS: if (!stall) m_mode = MR;
                default: m_mode = MI;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; stall = 1'b1; br_valid = 1'b1;
        tick(); tick();
        rst = 1'b0; start = 1'b0; stall = 1'b0; br_valid = 1'b0;
        checks++;
        if (pc !== 20'd0 || pc_valid !== 1'b0 || halted !== 1'b0 || run_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset: pc=%h valid=%b halted=%b cnt=%0d expected pc=0 valid=0 halted=0 cnt=0",
                     pc, pc_valid, halted, run_cnt);
        end
    endtask

    task automatic test_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            checks++;
            if (pc !== 20'(i) || pc_valid !== 1'b1 || halted !== 1'b0 ||
                run_cnt !== 32'(i) || pc !== m_pc || run_cnt !== 32'(m_cnt)) begin
                errors++;
                $display("FAIL start[%0d]: pc=%h valid=%b cnt=%0d expected pc=%h valid=1 cnt=%0d",
                         i, pc, pc_valid, run_cnt, i, i);
            end
        end
    endtask

    task automatic test_stall();
        logic        st [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [19:0] ep [5] = '{20'd5, 20'd5, 20'd5, 20'd5, 20'd6};
        logic        ev [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tick();
        for (int i = 0; i < 5; i++) begin
            stall = st[i];
            tick();
            checks++;
            if (pc !== ep[i] || pc_valid !== ev[i] || pc !== m_pc ||
                pc_valid !== 1'(m_mode == MR) || run_cnt !== 32'(m_cnt)) begin
                errors++;
                $display("FAIL stall[%0d]: pc=%h valid=%b cnt=%0d expected pc=%h valid=%b cnt=%0d",
                         i, pc, pc_valid, run_cnt, ep[i], ev[i], m_cnt);
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_branch();
        logic [19:0] exp_pc;
        tick();
        br_valid  = 1'b1;
        br_target = 20'h00100;
        exp_pc    = BR_EN ? 20'h00100 : 20'd8;
        checks++;
        if (pc !== 20'd7) begin
            errors++;
            $display("FAIL branch_pre: pc=%h expected pc=00007", pc);
        end
        tick();
        br_valid = 1'b0;
        checks++;
        if (pc !== exp_pc || pc_valid !== 1'b1 || pc !== m_pc) begin
            errors++;
            $display("FAIL branch: pc=%h valid=%b expected pc=%h valid=1", pc, pc_valid, exp_pc);
        end
    endtask

    task automatic test_simultaneous();
        logic        st [3] = '{1'b1, 1'b0, 1'b0};
        logic        bv [3] = '{1'b1, 1'b1, 1'b0};
        logic [19:0] ep [3] = '{20'd3, 20'd3, 20'd4};
        logic        ev [3] = '{1'b0, 1'b1, 1'b1};
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        br_target = 20'h00055;
        for (int i = 0; i < 3; i++) begin
            stall = st[i]; br_valid = bv[i];
            tick();
            checks++;
            if (pc !== ep[i] || pc_valid !== ev[i] || halted !== 1'b0 || pc !== m_pc) begin
                errors++;
                $display("FAIL simul[%0d]: pc=%h valid=%b expected pc=%h valid=%b",
                         i, pc, pc_valid, ep[i], ev[i]);
            end
        end
        stall = 1'b0; br_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while (pc !== 20'd9 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (pc !== 20'd9) begin
            errors++;
            $display("FAIL reset_mid_reach: pc=%h expected pc=00009 within 50 cycles", pc);
        end
        stall = 1'b1;
        tick();
        checks++;
        if (pc !== 20'd9 || pc_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stall: pc=%h valid=%b expected pc=00009 valid=0", pc, pc_valid);
        end
        rst = 1'b1; start = 1'b1; br_valid = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; stall = 1'b0; br_valid = 1'b0;
        checks++;
        if (pc !== 20'd0 || pc_valid !== 1'b0 || halted !== 1'b0 || run_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: pc=%h valid=%b halted=%b cnt=%0d expected pc=0 valid=0 halted=0 cnt=0",
                     pc, pc_valid, halted, run_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 39) == 0);
            start     = ($urandom_range(0, 7) == 0);
            stall     = ($urandom_range(0, 2) == 0);
            br_valid  = ($urandom_range(0, 3) == 0);
            br_target = 20'($urandom);
            tick();
            checks++;
            if (pc !== m_pc || pc_valid !== 1'(m_mode == MR) ||
                halted !== 1'(m_mode == MH) || run_cnt !== 32'(m_cnt)) begin
                errors++;
                $display("FAIL random[%0d]: pc=%h valid=%b halted=%b cnt=%0d expected pc=%h valid=%b halted=%b cnt=%0d",
                         i, pc, pc_valid, halted, run_cnt, m_pc, (m_mode == MR), (m_mode == MH), m_cnt);
            end
        end
        rst = 1'b0; start = 1'b0; stall = 1'b0; br_valid = 1'b0;
    endtask

    task automatic test_halt();
        logic [19:0] ep [4] = '{20'd1, 20'd4, 20'd7, 20'd10};
        rst1 = 1'b1; tick(); tick(); rst1 = 1'b0;
        start1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            start1 = 1'b0;
            checks++;
            if (pc1 !== ep[i] || pc_valid1 !== 1'b1 || halted1 !== 1'b0) begin
                errors++;
                $display("FAIL halt_seq[%0d]: pc=%h valid=%b halted=%b expected pc=%h valid=1 halted=0",
                         i, pc1, pc_valid1, halted1, ep[i]);
            end
        end
        stall1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (pc1 !== 20'd10 || pc_valid1 !== 1'b0 || halted1 !== 1'b1 || run_cnt1 !== 32'd4) begin
                errors++;
                $display("FAIL halt[%0d]: pc=%h valid=%b halted=%b cnt=%0d expected pc=0000a valid=0 halted=1 cnt=4",
                         i, pc1, pc_valid1, halted1, run_cnt1);
            end
        end
        stall1 = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++;
        if (pc1 !== 20'd1 || pc_valid1 !== 1'b1 || halted1 !== 1'b0) begin
            errors++;
            $display("FAIL halt_restart: pc=%h valid=%b halted=%b expected pc=00001 valid=1 halted=0",
                     pc1, pc_valid1, halted1);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] ep [8] = '{4'd14, 4'd3, 4'd8, 4'd13, 4'd2, 4'd7, 4'd12, 4'd1};
        rst2 = 1'b1; tick(); rst2 = 1'b0;
        start2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            start2 = 1'b0;
            checks++;
            if (pc2 !== ep[i] || pc_valid2 !== 1'b1 || halted2 !== 1'b0 || run_cnt2 !== 32'(i)) begin
                errors++;
                $display("FAIL wrap[%0d]: pc=%0d valid=%b halted=%b cnt=%0d expected pc=%0d valid=1 halted=0 cnt=%0d",
                         i, pc2, pc_valid2, halted2, run_cnt2, ep[i], i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_stall();
        test_branch();
        test_simultaneous();
        test_reset_mid();
        test_random();
        test_halt();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
